// File: rtl/uci_move_parser.sv
`default_nettype none
// ============================================================================
// Module   : uci_move_parser
// Purpose  : Parses a byte stream of UCI long-algebraic moves ("e2e4",
//            "e7e8q", ...) into packed moves. Well-formed tokens are handed
//            downstream through a valid/ready handshake. Malformed tokens
//            are dropped and flagged with a one-cycle error pulse.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_in          in   system clock, rising edge
//   rst_in          in   synchronous active-high reset
//   char_in[7:0]    in   ASCII byte from the host link
//   char_valid_in   in   char_in valid this cycle
//   char_ready_out  out  parser accepts a byte this cycle (low while a move
//                        is waiting for handoff)
//   move_out[14:0]  out  {special[2:0], src[5:0], dst[5:0]}
//                        coord = {row[2:0], col[2:0]}, a1 = 0, h8 = 63
//                        special: 0 unknown, 1 knight, 2 bishop, 3 rook,
//                                 4 queen (promotion piece)
//   valid_out       out  move_out valid, held until accepted
//   ready_in        in   downstream accepts move_out
//   error_out       out  one-cycle pulse: a malformed token was dropped
//   moves_out       out  count of moves handed off (wraps)
// ============================================================================
module uci_move_parser #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [7:0]       char_in,
    input  logic             char_valid_in,
    output logic             char_ready_out,
    output logic [14:0]      move_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             error_out,
    output logic [CNT_W-1:0] moves_out
);

    localparam logic [2:0] SPECIAL_UNKNOWN        = 3'd0;
    localparam logic [2:0] SPECIAL_PROMOTE_KNIGHT = 3'd1;
    localparam logic [2:0] SPECIAL_PROMOTE_BISHOP = 3'd2;
    localparam logic [2:0] SPECIAL_PROMOTE_ROOK   = 3'd3;
    localparam logic [2:0] SPECIAL_PROMOTE_QUEEN  = 3'd4;

    typedef enum logic [2:0] {
        ST_SRC_FILE = 3'd0,
        ST_SRC_RANK = 3'd1,
        ST_DST_FILE = 3'd2,
        ST_DST_RANK = 3'd3,
        ST_PROMO    = 3'd4,
        ST_END_TOK  = 3'd5,
        ST_EMIT     = 3'd6,
        ST_DISCARD  = 3'd7
    } state_t;

    state_t     state;
    logic [2:0] src_row, src_col, dst_row, dst_col;
    logic [2:0] special;

    // Character classification of the incoming byte
    logic       is_term, is_file, is_rank, is_promo;
    logic [2:0] idx;
    logic [2:0] promo_code;
    logic       same_square;

    assign is_term = (char_in == 8'h20) || (char_in == 8'h0A) || (char_in == 8'h0D);
    assign is_file = (char_in >= 8'h61) && (char_in <= 8'h68);   // 'a'..'h'
    assign is_rank = (char_in >= 8'h31) && (char_in <= 8'h38);   // '1'..'8'

    // 'a'..'h' = 0x61..0x68 and '1'..'8' = 0x31..0x38 share the same low
    // three bits, so (low3 - 1) mod 8 yields the 0..7 index for both.
    assign idx = char_in[2:0] - 3'd1;

    assign same_square = ({src_row, src_col} == {dst_row, dst_col});

    always_comb begin
        is_promo   = 1'b1;
        promo_code = SPECIAL_UNKNOWN;
        case (char_in)
            8'h6E:   promo_code = SPECIAL_PROMOTE_KNIGHT;  // 'n'
            8'h62:   promo_code = SPECIAL_PROMOTE_BISHOP;  // 'b'
            8'h72:   promo_code = SPECIAL_PROMOTE_ROOK;    // 'r'
            8'h71:   promo_code = SPECIAL_PROMOTE_QUEEN;   // 'q'
            default: is_promo   = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= ST_SRC_FILE;
            src_row        <= 3'd0;
            src_col        <= 3'd0;
            dst_row        <= 3'd0;
            dst_col        <= 3'd0;
            special        <= SPECIAL_UNKNOWN;
            move_out       <= 15'd0;
            valid_out      <= 1'b0;
            char_ready_out <= 1'b1;
            error_out      <= 1'b0;
            moves_out      <= '0;
        end else begin
            error_out <= 1'b0;
            if (state == ST_EMIT) begin
                // Byte input is stalled; only the handoff can leave EMIT.
                if (ready_in) begin
                    valid_out      <= 1'b0;
                    char_ready_out <= 1'b1;
                    moves_out      <= moves_out + {{(CNT_W-1){1'b0}}, 1'b1};
                    state          <= ST_SRC_FILE;
                end
            end else if (char_valid_in && char_ready_out) begin
                case (state)
                    ST_SRC_FILE: begin
                        if (is_file) begin
                            src_col <= idx;
                            state   <= ST_SRC_RANK;
                        end else if (!is_term) begin
                            state <= ST_DISCARD;
                        end
                    end
                    ST_SRC_RANK: begin
                        if (is_rank) begin
                            src_row <= idx;
                            state   <= ST_DST_FILE;
                        end else begin
                            state <= ST_DISCARD;
                        end
                    end
                    ST_DST_FILE: begin
                        if (is_file) begin
                            dst_col <= idx;
                            state   <= ST_DST_RANK;
                        end else begin
                            state <= ST_DISCARD;
                        end
                    end
                    ST_DST_RANK: begin
                        if (is_rank) begin
                            dst_row <= idx;
                            special <= SPECIAL_UNKNOWN;
                            state   <= ST_PROMO;
                        end else begin
                            state <= ST_DISCARD;
                        end
                    end
                    ST_PROMO, ST_END_TOK: begin
                        if (is_term) begin
                            // A null move (src == dst) is rejected only once
                            // the token is complete, like any other bad token.
                            if (same_square) begin
                                error_out <= 1'b1;
                                state     <= ST_SRC_FILE;
                            end else begin
                                move_out <= {(state == ST_PROMO) ? SPECIAL_UNKNOWN : special,
                                             src_row, src_col, dst_row, dst_col};
                                valid_out      <= 1'b1;
                                char_ready_out <= 1'b0;
                                state          <= ST_EMIT;
                            end
                        end else if ((state == ST_PROMO) && is_promo) begin
                            special <= promo_code;
                            state   <= ST_END_TOK;
                        end else begin
                            state <= ST_DISCARD;
                        end
                    end
                    ST_DISCARD: begin
                        if (is_term) begin
                            error_out <= 1'b1;
                            state     <= ST_SRC_FILE;
                        end
                    end
                    default: state <= ST_SRC_FILE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uci_move_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uci_move_parser
// Purpose  : Scoreboard bench for uci_move_parser. A token-level reference
//            model predicts moves/errors as bytes are accepted; a monitor
//            pops and compares whenever the parser presents an output.
// Revision : 1.0  initial release
// ============================================================================
module tb_uci_move_parser;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [7:0]  char_in;
    logic        char_valid_in;
    logic        char_ready_out;
    logic [14:0] move_out;
    logic        valid_out;
    logic        ready_in;
    logic        error_out;
    logic [15:0] moves_out;

    always #5 clk = ~clk;

    uci_move_parser #(.CNT_W(16)) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .char_in        (char_in),
        .char_valid_in  (char_valid_in),
        .char_ready_out (char_ready_out),
        .move_out       (move_out),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .error_out      (error_out),
        .moves_out      (moves_out)
    );

    typedef struct packed {
        logic        is_err;
        logic [14:0] mv;
    } exp_t;

    exp_t         exp_q[$];
    byte unsigned tok[$];
    bit           bad_pend;
    int           checks = 0;
    int           fails  = 0;
    logic [15:0]  hs_exp;
    bit           mon_en;
    bit           gaps;
    int           ready_mode;   // 0: always ready, 1: random, 2: stalled

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endfunction

    // ---------------- reference model (token level) ----------------
    function automatic bit t_term(byte unsigned c);
        return (c == 8'h20) || (c == 8'h0A) || (c == 8'h0D);
    endfunction

    function automatic bit t_file(byte unsigned c);
        return (c >= 8'h61) && (c <= 8'h68);
    endfunction

    function automatic bit t_rank(byte unsigned c);
        return (c >= 8'h31) && (c <= 8'h38);
    endfunction

    function automatic bit prefix_ok(int n);
        for (int i = 0; i < n; i++) begin
            if ((i % 2 == 0) && !t_file(tok[i])) return 1'b0;
            if ((i % 2 == 1) && !t_rank(tok[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void end_token();
        exp_t e;
        int   src, dst, sp;
        e = '0;
        if (bad_pend) begin
            e.is_err = 1'b1;
            exp_q.push_back(e);
            bad_pend = 1'b0;
        end else if (tok.size() == 0) begin
            // bare terminator between tokens: nothing happens
        end else if (tok.size() < 4 && prefix_ok(tok.size())) begin
            // token cut short by a terminator: parser swallows this
            // terminator and flags the error at the next one
            bad_pend = 1'b1;
        end else begin
            sp = -1;
            if (tok.size() == 4) sp = 0;
            else if (tok.size() == 5) begin
                case (tok[4])
                    8'h6E:   sp = 1;
                    8'h62:   sp = 2;
                    8'h72:   sp = 3;
                    8'h71:   sp = 4;
                    default: sp = -1;
                endcase
            end
            if (sp >= 0 && prefix_ok(4)) begin
                src = (int'(tok[1]) - 49) * 8 + (int'(tok[0]) - 97);
                dst = (int'(tok[3]) - 49) * 8 + (int'(tok[2]) - 97);
                if (src != dst) begin
                    e.mv = 15'(sp * 4096 + src * 64 + dst);
                end else begin
                    e.is_err = 1'b1;
                end
            end else begin
                e.is_err = 1'b1;
            end
            exp_q.push_back(e);
        end
        tok.delete();
    endfunction

    function automatic void model_byte(byte unsigned c);
        if (t_term(c)) end_token();
        else           tok.push_back(c);
    endfunction

    // ---------------- ready generator ----------------
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       ready_in = 1'b1;
            1:       ready_in = 1'($urandom_range(0, 1));
            default: ready_in = 1'b0;
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    bit   prev_valid;
    exp_t held;

    always @(negedge clk) begin
        exp_t e;
        if (!mon_en) begin
            prev_valid = 1'b0;
        end else begin
            if (error_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_error_pulse", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("error_where_move_expected", 32'd1, {31'd0, e.is_err});
                end
            end
            if (valid_out && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("move_where_error_expected", {31'd0, e.is_err}, 32'd0);
                    chk("move_out", {17'd0, move_out}, {17'd0, e.mv});
                    held = e;
                end
            end else if (valid_out) begin
                chk("move_out_hold", {17'd0, move_out}, {17'd0, held.mv});
            end
            chk("moves_out", {16'd0, moves_out}, {16'd0, hs_exp});
            if (valid_out && ready_in) hs_exp = hs_exp + 16'd1;
            prev_valid = valid_out;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(byte unsigned c);
        int t = 0;
        char_in       = c;
        char_valid_in = 1'b1;
        while (!char_ready_out && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            chk("char_ready_timeout", 32'd0, 32'd1);
            char_valid_in = 1'b0;
            return;
        end
        model_byte(c);
        @(negedge clk);
        char_valid_in = 1'b0;
        if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
    endtask

    task automatic send_str(string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || valid_out) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("drain_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        mon_en        = 1'b0;
        char_valid_in = 1'b0;
        rst_in        = 1'b1;
        repeat (2) @(negedge clk);
        rst_in = 1'b0;
        tok.delete();
        bad_pend = 1'b0;
        exp_q.delete();
        hs_exp = 16'd0;
        @(negedge clk);
        chk("reset_valid_out", {31'd0, valid_out}, 32'd0);
        chk("reset_error_out", {31'd0, error_out}, 32'd0);
        chk("reset_moves_out", {16'd0, moves_out}, 32'd0);
        chk("reset_char_ready", {31'd0, char_ready_out}, 32'd1);
        mon_en = 1'b1;
    endtask

    task automatic rand_token();
        int    r;
        int    n;
        int    f1, r1, f2, r2;
        string alpha = "abcdefgh12345678nbrqz9A";
        r = $urandom_range(0, 9);
        if (r < 6) begin
            f1 = $urandom_range(0, 7); r1 = $urandom_range(0, 7);
            f2 = $urandom_range(0, 7); r2 = $urandom_range(0, 7);
            if (r == 0) begin f2 = f1; r2 = r1; end
            send_byte(8'(97 + f1)); send_byte(8'(49 + r1));
            send_byte(8'(97 + f2)); send_byte(8'(49 + r2));
            if ($urandom_range(0, 2) == 0) send_byte(alpha[16 + $urandom_range(0, 3)]);
        end else if (r < 9) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) send_byte(alpha[$urandom_range(0, alpha.len() - 1)]);
        end
        n = $urandom_range(1, 2);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 2))
                0:       send_byte(8'h20);
                1:       send_byte(8'h0A);
                default: send_byte(8'h0D);
            endcase
        end
    endtask

    initial begin
        int t;
        rst_in        = 1'b1;
        char_in       = 8'h00;
        char_valid_in = 1'b0;
        ready_in      = 1'b0;
        ready_mode    = 0;
        mon_en        = 1'b0;
        gaps          = 1'b0;
        bad_pend      = 1'b0;
        hs_exp        = 16'd0;
        repeat (3) @(negedge clk);
        rst_in = 1'b0;
        @(negedge clk);
        chk("reset_valid_out", {31'd0, valid_out}, 32'd0);
        chk("reset_error_out", {31'd0, error_out}, 32'd0);
        chk("reset_moves_out", {16'd0, moves_out}, 32'd0);
        chk("reset_move_out", {17'd0, move_out}, 32'd0);
        chk("reset_char_ready", {31'd0, char_ready_out}, 32'd1);
        mon_en = 1'b1;

        send_str("e2e4\n");
        drain();
        chk("moves_after_e2e4", {16'd0, moves_out}, 32'd1);
        send_str("e7e8q ");
        send_str("e1g1\r");
        drain();

        send_str("e2e9\n");
        send_str("a1a1 ");
        send_str("e7e8qq\n");
        drain();
        chk("moves_after_bad_tokens", {16'd0, moves_out}, 32'd3);
        send_str("d2d4\n");
        drain();

        // backpressure: first move held while the second waits at the source
        ready_mode = 2;
        @(negedge clk);
        fork
            send_str("g1f3 b8c6 ");
        join_none
        t = 0;
        while (!valid_out && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("backpressure_valid_seen", {31'd0, valid_out}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_char_ready", {31'd0, char_ready_out}, 32'd0);
            chk("stall_valid_held", {31'd0, valid_out}, 32'd1);
        end
        ready_mode = 0;
        wait fork;
        drain();
        chk("moves_after_backpressure", {16'd0, moves_out}, 32'd6);

        // reset drops a partial token
        send_str("e2e");
        do_reset();
        send_str("d7d5\n");
        drain();
        chk("moves_after_reset", {16'd0, moves_out}, 32'd1);

        send_str("\n\n  h7h8n\n");
        drain();

        // randomized traffic with random backpressure and input gaps
        ready_mode = 1;
        gaps       = 1'b1;
        for (int i = 0; i < 250; i++) rand_token();
        drain();
        chk("final_queue_empty", exp_q.size(), 32'd0);
        chk("final_moves_out", {16'd0, moves_out}, {16'd0, hs_exp});

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
`default_nettype wire
